// File: rtl/pipe_ctrl_regs_if.sv
// pipe_ctrl_regs_if: bundle between the ID decoder / EX-MEM datapath and
// the pipeline control register block.
//   master: decoder/datapath side, drives ID fields, flush, ALU result and
//           memory read data; observes stage tags, write-back and stall.
//   slave : pipe_ctrl_regs side, the mirror image.
interface pipe_ctrl_regs_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // ID-stage inputs
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_regwrite, id_memread, id_memtoreg;
    logic              flush;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] mem_read_data;

    // ID/EX
    logic [4:0]        Rs_id_ex, Rt_id_ex, Rd_id_ex;
    logic              RegWrite_id_ex, MemRead_id_ex, MemToReg_id_ex;
    // EX/MEM
    logic [4:0]        Rd_ex_mem;
    logic              RegWrite_ex_mem, MemRead_ex_mem, MemToReg_ex_mem;
    logic [DATA_W-1:0] alu_result_ex_mem;
    // MEM/WB
    logic [4:0]        Rd_mem_wb;
    logic              RegWrite_mem_wb, MemToReg_mem_wb;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    // hazard
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, id_memtoreg,
               flush, ex_alu_result, mem_read_data,
        input  Rs_id_ex, Rt_id_ex, Rd_id_ex, RegWrite_id_ex, MemRead_id_ex, MemToReg_id_ex,
               Rd_ex_mem, RegWrite_ex_mem, MemRead_ex_mem, MemToReg_ex_mem, alu_result_ex_mem,
               Rd_mem_wb, RegWrite_mem_wb, MemToReg_mem_wb, wb_data, wb_we, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, id_memtoreg,
               flush, ex_alu_result, mem_read_data,
        output Rs_id_ex, Rt_id_ex, Rd_id_ex, RegWrite_id_ex, MemRead_id_ex, MemToReg_id_ex,
               Rd_ex_mem, RegWrite_ex_mem, MemRead_ex_mem, MemToReg_ex_mem, alu_result_ex_mem,
               Rd_mem_wb, RegWrite_mem_wb, MemToReg_mem_wb, wb_data, wb_we, stall, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// pipe_ctrl_regs: destination-tag / control pipeline registers for the
// ID/EX, EX/MEM and MEM/WB stages of the 5-stage MIPS core.
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - asynchronous, active-high; every stage becomes a bubble
//   bus   - pipe_ctrl_regs_if.slave: ID fields in, stage tags, write-back
//           data/enable, load-use stall and saturating stall counter out
module pipe_ctrl_regs #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_regs_if.slave bus
);
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
        logic       memToReg;
    } idExT;

    idExT              idEx, idExNext;
    logic              loadUse;

    logic [4:0]        rdExMem;
    logic              regWriteExMem, memReadExMem, memToRegExMem;
    logic [DATA_W-1:0] aluResultExMem;

    logic [4:0]        rdMemWb;
    logic              regWriteMemWb, memToRegMemWb;
    logic [DATA_W-1:0] readDataMemWb, aluResultMemWb;

    logic [CNT_W-1:0]  stallCnt;

    // A load in EX whose target is read by the instruction in ID must wait
    // one cycle. $0 is never a real dependency.
    always_comb begin
        loadUse = bus.id_valid && idEx.memRead && (idEx.rt != 5'd0) &&
                  ((idEx.rt == bus.id_rs) || (idEx.rt == bus.id_rt));
    end

    // Stall, flush and an empty ID slot all collapse to the same bubble.
    always_comb begin
        idExNext = '0;
        if (bus.id_valid && !loadUse && !bus.flush) begin
            idExNext.rs       = bus.id_rs;
            idExNext.rt       = bus.id_rt;
            idExNext.rd       = bus.id_rd;
            idExNext.regWrite = bus.id_regwrite;
            idExNext.memRead  = bus.id_memread;
            idExNext.memToReg = bus.id_memtoreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idEx           <= '0;
            rdExMem        <= '0;
            regWriteExMem  <= 1'b0;
            memReadExMem   <= 1'b0;
            memToRegExMem  <= 1'b0;
            aluResultExMem <= '0;
            rdMemWb        <= '0;
            regWriteMemWb  <= 1'b0;
            memToRegMemWb  <= 1'b0;
            readDataMemWb  <= '0;
            aluResultMemWb <= '0;
            stallCnt       <= '0;
        end else begin
            idEx           <= idExNext;
            // EX/MEM and MEM/WB never hold: the bubble inserted above is
            // what protects the later stages during a stall.
            rdExMem        <= idEx.rd;
            regWriteExMem  <= idEx.regWrite;
            memReadExMem   <= idEx.memRead;
            memToRegExMem  <= idEx.memToReg;
            aluResultExMem <= bus.ex_alu_result;
            rdMemWb        <= rdExMem;
            regWriteMemWb  <= regWriteExMem;
            memToRegMemWb  <= memToRegExMem;
            readDataMemWb  <= bus.mem_read_data;
            aluResultMemWb <= aluResultExMem;
            if (loadUse && (stallCnt != {CNT_W{1'b1}}))
                stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.Rs_id_ex          = idEx.rs;
    assign bus.Rt_id_ex          = idEx.rt;
    assign bus.Rd_id_ex          = idEx.rd;
    assign bus.RegWrite_id_ex    = idEx.regWrite;
    assign bus.MemRead_id_ex     = idEx.memRead;
    assign bus.MemToReg_id_ex    = idEx.memToReg;
    assign bus.Rd_ex_mem         = rdExMem;
    assign bus.RegWrite_ex_mem   = regWriteExMem;
    assign bus.MemRead_ex_mem    = memReadExMem;
    assign bus.MemToReg_ex_mem   = memToRegExMem;
    assign bus.alu_result_ex_mem = aluResultExMem;
    assign bus.Rd_mem_wb         = rdMemWb;
    assign bus.RegWrite_mem_wb   = regWriteMemWb;
    assign bus.MemToReg_mem_wb   = memToRegMemWb;
    assign bus.wb_data           = memToRegMemWb ? readDataMemWb : aluResultMemWb;
    // $0 is hardwired zero, so a write to it is dropped here.
    assign bus.wb_we             = regWriteMemWb && (rdMemWb != 5'd0);
    assign bus.stall             = loadUse;
    assign bus.stall_cnt         = stallCnt;
endmodule

// File: doc/pipe_ctrl_regs.md
# pipe_ctrl_regs

- Holds the destination-tag and control pipeline registers for the ID/EX, EX/MEM and MEM/WB stages of the 5-stage MIPS core.
- Drives the tags the forwarding unit consumes: Rs_id_ex, Rt_id_ex, Rd_ex_mem, Rd_mem_wb, RegWrite_ex_mem, RegWrite_mem_wb.
- Detects load-use hazards, inserts bubbles on stall or flush, selects write-back data and counts stall cycles.
- Sits between the ID decoder and the EX/MEM/WB datapath.

## Interface
Parameters:
- DATA_W, 32, width of ALU result / memory data
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_rd  in  5  destination already chosen by RegDst
- id_regwrite, id_memread, id_memtoreg  in  1 each  decoded control
- flush  in  1  branch/jump taken; kill the instruction in ID
- ex_alu_result  in  DATA_W  EX-stage ALU output (computed from ID/EX contents)
- mem_read_data  in  DATA_W  data memory read output in MEM
- Rs_id_ex, Rt_id_ex, Rd_id_ex  out  5 each  ID/EX tags
- RegWrite_id_ex, MemRead_id_ex, MemToReg_id_ex  out  1 each
- Rd_ex_mem  out  5; RegWrite_ex_mem, MemRead_ex_mem, MemToReg_ex_mem  out  1 each
- alu_result_ex_mem  out  DATA_W
- Rd_mem_wb  out  5; RegWrite_mem_wb, MemToReg_mem_wb  out  1 each
- wb_data  out  DATA_W  register-file write data
- wb_we  out  1  register-file write enable
- stall  out  1  hold PC and IF/ID this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Bubble: all ID/EX controls 0; Rs/Rt/Rd 0.
- Load-use stall (combinational) is asserted when all of these hold:
  - id_valid
  - MemRead_id_ex
  - Rt_id_ex != 0
  - Rt_id_ex == id_rs or Rt_id_ex == id_rt
- ID/EX update on each edge:
  - Loads a bubble if stall or flush (flush priority irrelevant; result identical).
  - Loads a bubble if id_valid = 0.
  - Otherwise loads id_rs, id_rt, id_rd, id_regwrite, id_memread, id_memtoreg.
- EX/MEM: always loads from ID/EX plus ex_alu_result. No stall or hold.
- MEM/WB: always loads from EX/MEM plus mem_read_data.
  - Internally registers read_data_mem_wb and alu_result_mem_wb.
- wb_data = MemToReg_mem_wb ? read_data_mem_wb : alu_result_mem_wb. Combinational.
- wb_we = RegWrite_mem_wb && (Rd_mem_wb != 0).
- stall_cnt increments on every edge where stall = 1; holds at 2^CNT_W-1.
- Writes to $0 never assert wb_we. Register-file ordering (write-before-read) is outside this block.

## Timing
- Reset (async, immediate): every registered output 0, i.e. all stages are bubbles.
  - stall_cnt = 0, wb_data = 0, wb_we = 0, stall = 0.
- An instruction entering ID at edge N:
  - Appears on ID/EX outputs after edge N+1.
  - Appears on EX/MEM after N+2.
  - Appears on MEM/WB and drives wb_we after N+3.
- stall and wb_data/wb_we are same-cycle combinational from the registers; there is no added latency.
- A stall lasts exactly one cycle per load-use pair: after the bubble edge MemRead_id_ex = 0, so stall drops.
- Simultaneous stall and flush: single bubble. stall_cnt still increments.
- Reset mid-stall clears stall the same cycle. Counter restarts from 0.
- id_valid = 0 with a matching tag produces no stall.

## Test plan
- Reset:
  - Stimulus: drive non-zero ID inputs, assert reset between edges.
  - Required: all outputs 0 immediately; after release, first valid instruction (rd=5, regwrite=1) gives RegWrite_mem_wb=1, Rd_mem_wb=5 three edges later.
- Propagation:
  - Stimulus: lw rt=3 (memread, memtoreg, regwrite, rd=3), mem_read_data=0xDEADBEEF at its MEM cycle.
  - Required: wb_data=0xDEADBEEF, wb_we=1 at N+3; add rd=4 with ex_alu_result=0x12 gives wb_data=0x12.
- Load-use:
  - Stimulus: lw rt=3, then next ID instruction rs=3.
  - Required: stall=1 for exactly one cycle, ID/EX bubble (RegWrite_id_ex=0, Rt_id_ex=0), stall_cnt=1; the dependent instruction enters ID/EX one cycle later.
- No false stall:
  - Stimulus: lw rt=0 followed by rs=0; lw rt=3 followed by id_valid=0 with rs=3.
  - Required: stall=0 in both cases.
- Flush and stall together:
  - Stimulus: flush=1 in the load-use cycle.
  - Required: one bubble in ID/EX, stall_cnt +1, EX/MEM still advances the lw.
- Saturation and $0:
  - Stimulus: CNT_W=4 with 20 stall cycles; separately, instruction with rd=0, regwrite=1.
  - Required: stall_cnt=15 and held; wb_we=0.
